// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands selected per operation.
// Latency: done pulses N_BITS+1 cycles after the accepted start; one product every N_BITS+2 cycles.
// Backpressure: none; start is accepted only in IDLE or DONE and is ignored while busy.
//
// Ports:
//   clk, rst     - clock (rising edge) and asynchronous active-high reset
//   start        - operation request, sampled when idle or in the done cycle
//   signed_mode  - 1 = two's complement operands/product, 0 = unsigned; sampled with start
//   mpd, mpr     - multiplicand (M_BITS) and multiplier (N_BITS), sampled with start
//   prod         - product register, valid with done and held until the next result
//   busy, done   - registered status: iterating / one-cycle result-valid pulse
module booth_mult_seq #(
    parameter int M_BITS   = 12,
    parameter int N_BITS   = 8,
    parameter int CNT_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [M_BITS-1:0]          mpd,
    input  logic [N_BITS-1:0]          mpr,
    output logic [M_BITS+N_BITS-1:0]   prod,
    output logic                       busy,
    output logic                       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [M_BITS:0]   ONE_A  = 1;
    localparam logic [CNT_BITS-1:0] ONE_C = 1;
    // The final iteration is the one entered with count == N_BITS (N_BITS+1 iterations total,
    // because Q carries the extension bit as an extra multiplier digit).
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(N_BITS);

    logic [1:0]          state;
    logic [M_BITS:0]     a_reg;
    logic [M_BITS:0]     m_reg;
    logic [N_BITS:0]     q_reg;
    logic                q_1;
    logic [CNT_BITS-1:0] count;

    logic                load;
    logic [M_BITS:0]     a_sum;
    logic [M_BITS:0]     a_nxt;
    logic [N_BITS:0]     q_nxt;
    logic                q_1_nxt;

    assign load = start && ((state == S_IDLE) || (state == S_DONE));

    // Booth digit from {Q[0], Q_1}: 01 adds M, 10 subtracts M, otherwise A is kept.
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg + (~m_reg) + ONE_A;
            default: a_sum = a_reg;
        endcase
    end

    // Arithmetic right shift of {A', Q, Q_1}: A's sign bit is replicated, old Q_1 falls off.
    assign {a_nxt, q_nxt, q_1_nxt} = {a_sum[M_BITS], a_sum, q_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            a_reg <= '0;
            m_reg <= '0;
            q_reg <= '0;
            q_1   <= 1'b0;
            count <= '0;
            prod  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Extending both operands by one bit (sign or zero) lets the same
                // signed Booth datapath serve both modes.
                a_reg <= '0;
                m_reg <= {signed_mode & mpd[M_BITS-1], mpd};
                q_reg <= {signed_mode & mpr[N_BITS-1], mpr};
                q_1   <= 1'b0;
                count <= '0;
                busy  <= 1'b1;
                state <= S_RUN;
            end else if (state == S_RUN) begin
                a_reg <= a_nxt;
                q_reg <= q_nxt;
                q_1   <= q_1_nxt;
                count <= count + ONE_C;
                if (count == LAST_CNT) begin
                    // Low M_BITS+N_BITS bits of {A,Q}: all of Q plus the low M_BITS-1 bits of A.
                    prod  <= {a_nxt[M_BITS-2:0], q_nxt};
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
            end else if (state != S_IDLE) begin
                // DONE without a new start, or an unreachable encoding.
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random bench for booth_mult_seq at default parameters (12 x 8).
// Latency: checks done 9 cycles after the start edge and a 10-cycle repeat with start held.
// Backpressure: exercises start ignored mid-run and asynchronous reset mid-run.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [11:0] mpd;
    logic [7:0]  mpr;
    logic [19:0] prod;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [19:0] last_prod;

    booth_mult_seq #(.M_BITS(12), .N_BITS(8), .CNT_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .mpd         (mpd),
        .mpr         (mpr),
        .prod        (prod),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Product modulo 2**20 of the sign- or zero-extended operands.
    function automatic logic [19:0] ref_mul(input logic sm, input logic [11:0] a, input logic [7:0] b);
        logic [19:0] ea;
        logic [19:0] eb;
        if (sm) begin
            ea = {{8{a[11]}}, a};
            eb = {{12{b[7]}}, b};
        end else begin
            ea = {8'd0, a};
            eb = {12'd0, b};
        end
        return ea * eb;
    endfunction

    // One operation: start for one cycle, scramble inputs during RUN, wait for done,
    // check result, latency and that the previous product is held mid-run.
    task automatic do_op(input logic sm, input logic [11:0] a, input logic [7:0] b,
                         input logic [19:0] exp_p, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; mpd = a; mpr = b;
        @(negedge clk);
        start = 1'b0; signed_mode = ~sm; mpd = 12'($urandom); mpr = 8'($urandom);
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (lat == 4) check_val("prod_hold", 32'(prod), 32'(last_prod));
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) check_val("done_timeout", 32'(done), 32'd1);
        check_val("latency", 32'(lat), 32'd9);
        check_val("prod", 32'(prod), 32'(exp_p));
        last_prod = exp_p;
    endtask

    initial begin
        int lat;
        int bcnt;
        int k;
        int dcnt;
        logic        rs;
        logic [11:0] ra;
        logic [7:0]  rb;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; mpd = '0; mpr = '0;
        last_prod = '0;
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_prod", 32'(prod), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: -3 x 5, busy width and single done pulse
        do_op(1'b1, 12'hFFD, 8'h05, 20'hFFFF1, lat, bcnt);
        check_val("busy_cycles", 32'(bcnt), 32'd9);
        @(negedge clk);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("busy_after", 32'(busy), 32'd0);

        // 2: all-ones operands in both modes
        do_op(1'b0, 12'hFFF, 8'hFF, 20'hFEF01, lat, bcnt);
        do_op(1'b1, 12'hFFF, 8'hFF, 20'h00001, lat, bcnt);

        // 3: signed extremes
        do_op(1'b1, 12'h800, 8'h80, 20'h40000, lat, bcnt);
        do_op(1'b1, 12'h7FF, 8'h80, 20'hC0080, lat, bcnt);

        // 4a: start pulsed mid-run is ignored
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; mpd = 12'hFFD; mpr = 8'h05;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 3) begin
                start = 1'b1; signed_mode = 1'b0; mpd = 12'd7; mpr = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_val("ign_latency", 32'(lat), 32'd9);
        check_val("ign_prod", 32'(prod), 32'hFFFF1);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check_val("ign_no_extra_done", 32'(dcnt), 32'd0);
        last_prod = 20'hFFFF1;

        // 4b: start held high -> back-to-back results every 10 cycles
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; mpd = 12'd7; mpr = 8'd9;
        lat = -1;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 40);
        check_val("b2b_first_lat", 32'(lat), 32'd9);
        check_val("b2b_first_prod", 32'(prod), 32'd63);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < 40);
        start = 1'b0;
        check_val("b2b_period", 32'(k), 32'd10);
        check_val("b2b_second_prod", 32'(prod), 32'd63);
        repeat (2) @(negedge clk);
        check_val("b2b_idle_busy", 32'(busy), 32'd0);
        last_prod = 20'd63;

        // 5: asynchronous reset between clock edges mid-run
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; mpd = 12'h800; mpr = 8'h80;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_prod", 32'(prod), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check_val("arst_no_done", 32'(dcnt), 32'd0);
        check_val("arst_idle_busy", 32'(busy), 32'd0);
        last_prod = 20'd0;

        // 6: random vectors in both modes
        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 12'($urandom);
            rb = 8'($urandom);
            do_op(rs, ra, rb, ref_mul(rs, ra, rb), lat, bcnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
